muladd_vec: RTL and testbench

Parametrised RTL successor to the fixed 16-element HLS dot-product core. Computes sum(a[i]*b[i]) for i = 0..len-1 over two single-port synchronous memories. Element width, depth and signedness are parameters; vector length is set at run time. Uses the ap_ctrl_hs handshake (start/done/idle/ready, ap_return) so it drops into the existing accelerator benches and wrappers.

---
 rtl/muladd_vec_if.sv | 33 +++
 rtl/muladd_vec.sv | 190 +++++++++++++++++++
 tb/tb_muladd_vec.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/muladd_vec_if.sv
// Handshake and memory-port bundle for muladd_vec (ap_ctrl_hs control plus two single-port reads).
// The slave modport is the core's view; the master modport is the driver/memory side.
interface muladd_vec_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int ACC_W  = 32
);
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] a_address0;
  logic              a_ce0;
  logic [DATA_W-1:0] a_q0;
  logic [ADDR_W-1:0] b_address0;
  logic              b_ce0;
  logic [DATA_W-1:0] b_q0;
  logic [ACC_W-1:0]  ap_return;
  logic              ap_ovf;

  modport slave (
    input  ap_start, len, a_q0, b_q0,
    output ap_done, ap_idle, ap_ready, a_address0, a_ce0, b_address0, b_ce0,
           ap_return, ap_ovf
  );

  modport master (
    output ap_start, len, a_q0, b_q0,
    input  ap_done, ap_idle, ap_ready, a_address0, a_ce0, b_address0, b_ce0,
           ap_return, ap_ovf
  );
endinterface

// File: rtl/muladd_vec.sv
// muladd_vec: run-time length dot product sum(a[i]*b[i]) over two single-port memories, ap_ctrl_hs.
// Define MULADD_VEC_SAT_EN to saturate the accumulator and report clamps on ap_ovf; default wraps.
module muladd_vec #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 0
) (
  input logic         ap_clk,
  input logic         ap_rst_n,
  muladd_vec_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(32'd1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(32'd1);
`ifdef MULADD_VEC_SAT_EN
  localparam logic [ACC_W-1:0]  ACC_MAX_S = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]  ACC_MIN_S = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0]  ACC_MAX_U = {ACC_W{1'b1}};
`endif

  // Returns {clamped, acc + p}; clamping only exists in the saturating build.
  function automatic logic [ACC_W:0] add_acc(input logic [ACC_W-1:0] acc,
                                             input logic [ACC_W-1:0] p);
    logic [ACC_W:0] res;
`ifdef MULADD_VEC_SAT_EN
    logic [ACC_W:0]   wide;
    logic [ACC_W-1:0] sum;
    wide = {1'b0, acc} + {1'b0, p};
    sum  = wide[ACC_W-1:0];
    if (SIGNED != 0) begin
      if ((acc[ACC_W-1] == p[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1])) begin
        res = {1'b1, (p[ACC_W-1] ? ACC_MIN_S : ACC_MAX_S)};
      end else begin
        res = {1'b0, sum};
      end
    end else begin
      if (wide[ACC_W]) begin
        res = {1'b1, ACC_MAX_U};
      end else begin
        res = {1'b0, sum};
      end
    end
`else
    res = {1'b0, acc + p};
`endif
    return res;
  endfunction

  state_t            state_r, state_s;
  logic [ADDR_W:0]   len_r, len_s, len_clamp_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              ce_r, ce_s;
  logic              rd_vld_r;
  logic [ACC_W-1:0]  acc_r, acc_s;
  logic              ovf_r, ovf_s;
  logic [ACC_W-1:0]  ret_r, ret_s;
  logic              done_r, done_s;
  logic              idle_r, idle_s;

  logic [2*DATA_W-1:0] a_ext_s, b_ext_s, prod_s;
  logic [ACC_W-1:0]    prod_ext_s;
  logic [ACC_W:0]      sum_s;

  // Product of the word returned for the previous address, extended to ACC_W.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext_s    = (2*DATA_W)'($signed(bus.a_q0));
      b_ext_s    = (2*DATA_W)'($signed(bus.b_q0));
      prod_s     = a_ext_s * b_ext_s;
      prod_ext_s = ACC_W'($signed(prod_s));
    end else begin
      a_ext_s    = (2*DATA_W)'(bus.a_q0);
      b_ext_s    = (2*DATA_W)'(bus.b_q0);
      prod_s     = a_ext_s * b_ext_s;
      prod_ext_s = ACC_W'(prod_s);
    end
    sum_s = add_acc(acc_r, prod_ext_s);
    if (bus.len > DEPTH_L) begin
      len_clamp_s = DEPTH_L;
    end else begin
      len_clamp_s = bus.len;
    end
  end

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_s = state_r;
    len_s   = len_r;
    addr_s  = addr_r;
    ce_s    = 1'b0;
    ret_s   = ret_r;
    done_s  = 1'b0;
    idle_s  = 1'b0;
    if (rd_vld_r) begin
      acc_s = sum_s[ACC_W-1:0];
      ovf_s = ovf_r | sum_s[ACC_W];
    end else begin
      acc_s = acc_r;
      ovf_s = ovf_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (bus.ap_start) begin
          len_s  = len_clamp_s;
          acc_s  = '0;
          ovf_s  = 1'b0;
          addr_s = '0;
          // A zero-length run still spends one flush cycle so done lands len_eff+2 after start.
          if (len_clamp_s == '0) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_RUN;
            ce_s    = 1'b1;
          end
        end else begin
          idle_s = 1'b1;
        end
      end
      ST_RUN: begin
        if ({1'b0, addr_r} == (len_r - LEN_ONE)) begin
          state_s = ST_DRAIN;
        end else begin
          addr_s = addr_r + ADDR_ONE;
          ce_s   = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_s = ST_DONE;
        done_s  = 1'b1;
        ret_s   = acc_s;
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        idle_s  = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
        idle_s  = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r  <= ST_IDLE;
      len_r    <= '0;
      addr_r   <= '0;
      ce_r     <= 1'b0;
      rd_vld_r <= 1'b0;
      acc_r    <= '0;
      ovf_r    <= 1'b0;
      ret_r    <= '0;
      done_r   <= 1'b0;
      idle_r   <= 1'b1;
    end else begin
      state_r  <= state_s;
      len_r    <= len_s;
      addr_r   <= addr_s;
      ce_r     <= ce_s;
      rd_vld_r <= ce_r;
      acc_r    <= acc_s;
      ovf_r    <= ovf_s;
      ret_r    <= ret_s;
      done_r   <= done_s;
      idle_r   <= idle_s;
    end
  end

  assign bus.a_address0 = addr_r;
  assign bus.b_address0 = addr_r;
  assign bus.a_ce0      = ce_r;
  assign bus.b_ce0      = ce_r;
  assign bus.ap_done    = done_r;
  assign bus.ap_ready   = done_r;
  assign bus.ap_idle    = idle_r;
  assign bus.ap_return  = ret_r;
  assign bus.ap_ovf     = ovf_r;

endmodule

// File: tb/tb_muladd_vec.sv
// Testbench for muladd_vec: an unsigned and a signed instance share the same memory contents
// and are driven together from a table of directed vectors plus hand-written corner sequences.
module tb_muladd_vec;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int ACC_W  = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  muladd_vec_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) bus_u ();
  muladd_vec_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) bus_s ();

  muladd_vec #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .SIGNED(0))
    u_dut_u (.ap_clk(clk), .ap_rst_n(rst_n), .bus(bus_u));
  muladd_vec #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .SIGNED(1))
    u_dut_s (.ap_clk(clk), .ap_rst_n(rst_n), .bus(bus_s));

  logic [15:0] a_mem [16];
  logic [15:0] b_mem [16];

  always @(posedge clk) begin
    if (bus_u.a_ce0) bus_u.a_q0 <= a_mem[bus_u.a_address0];
    if (bus_u.b_ce0) bus_u.b_q0 <= b_mem[bus_u.b_address0];
    if (bus_s.a_ce0) bus_s.a_q0 <= a_mem[bus_s.a_address0];
    if (bus_s.b_ce0) bus_s.b_q0 <= b_mem[bus_s.b_address0];
  end

  typedef struct {
    int          pat;
    int          len;
    bit          glitch;
    logic [31:0] exp_u;
    logic [31:0] exp_s;
    logic        ovf_u;
    logic        ovf_s;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [15:0] pat_a(input int p, input int i);
    case (p)
      0:       return 16'(i);
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      default: return 16'h8000;
    endcase
  endfunction

  function automatic logic [15:0] pat_b(input int p, input int i);
    case (p)
      0:       return 16'(i + 1);
      1:       return 16'd2;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'h7FFF;
    endcase
  endfunction

  task automatic fill_mem(input int p);
    for (int j = 0; j < 16; j++) begin
      a_mem[j] = pat_a(p, j);
      b_mem[j] = pat_b(p, j);
    end
  endtask

  task automatic set_start(input logic s, input int l);
    bus_u.ap_start = s;
    bus_s.ap_start = s;
    bus_u.len      = 5'(l);
    bus_s.len      = 5'(l);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_one(input int l, input bit glitch, output int cyc, output int ce_cnt,
                         output int max_addr, output int idle_low);
    cyc = 0; ce_cnt = 0; max_addr = 0; idle_low = 0;
    @(negedge clk);
    set_start(1'b1, l);
    @(posedge clk);
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) set_start(1'b0, l);
      if (glitch && cyc == 2) set_start(1'b1, 1);
      if (glitch && cyc == 3) set_start(1'b0, l);
      if (bus_u.a_ce0) begin
        ce_cnt++;
        if (int'(bus_u.a_address0) > max_addr) max_addr = int'(bus_u.a_address0);
      end
      if (!bus_u.ap_idle) idle_low++;
    end while (!bus_u.ap_done && cyc < 64);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    cyc, ce_cnt, max_addr, idle_low, leff, first, second;
    bit    found;
    string tag;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_start(1'b0, 0);
    fill_mem(0);

    vecs[0] = '{0, 16, 1'b0, 32'h0000_0550, 32'h0000_0550, 1'b0, 1'b0};
    vecs[1] = '{0,  4, 1'b1, 32'h0000_0014, 32'h0000_0014, 1'b0, 1'b0};
    vecs[2] = '{0, 20, 1'b0, 32'h0000_0550, 32'h0000_0550, 1'b0, 1'b0};
    vecs[3] = '{0,  0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[4] = '{1, 16, 1'b0, 32'h001F_FFE0, 32'hFFFF_FFE0, 1'b0, 1'b0};
    vecs[5] = '{1,  5, 1'b0, 32'h0009_FFF6, 32'hFFFF_FFF6, 1'b0, 1'b0};
`ifdef MULADD_VEC_SAT_EN
    vecs[6] = '{2, 16, 1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[7] = '{3,  2, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
`else
    vecs[6] = '{2, 16, 1'b0, 32'hFFF0_0010, 32'hFFF0_0010, 1'b0, 1'b0};
    vecs[7] = '{3,  2, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};
`endif
    vecs[8] = '{4,  1, 1'b0, 32'h3FFF_8000, 32'hC000_8000, 1'b0, 1'b0};
    vecs[9] = '{0, 15, 1'b0, 32'h0000_0460, 32'h0000_0460, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_idle",   32'(bus_u.ap_idle),    32'd1);
    chk("reset_done",   32'(bus_u.ap_done),    32'd0);
    chk("reset_ready",  32'(bus_s.ap_ready),   32'd0);
    chk("reset_ce",     32'(bus_u.a_ce0),      32'd0);
    chk("reset_addr",   32'(bus_s.b_address0), 32'd0);
    chk("reset_return", bus_u.ap_return,       32'd0);
    chk("reset_ovf",    32'(bus_s.ap_ovf),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(bus_s.ap_idle), 32'd1);

    for (int v = 0; v < 10; v++) begin
      leff = (vecs[v].len > DEPTH) ? DEPTH : vecs[v].len;
      fill_mem(vecs[v].pat);
      run_one(vecs[v].len, vecs[v].glitch, cyc, ce_cnt, max_addr, idle_low);
      tag = $sformatf("v%0d_len%0d", v, vecs[v].len);
      chk({tag, "_ret_u"},    bus_u.ap_return,        vecs[v].exp_u);
      chk({tag, "_ret_s"},    bus_s.ap_return,        vecs[v].exp_s);
      chk({tag, "_ovf_u"},    32'(bus_u.ap_ovf),      32'(vecs[v].ovf_u));
      chk({tag, "_ovf_s"},    32'(bus_s.ap_ovf),      32'(vecs[v].ovf_s));
      chk({tag, "_latency"},  32'(cyc),               32'(leff + 2));
      chk({tag, "_done_s"},   32'(bus_s.ap_done),     32'd1);
      chk({tag, "_ready"},    32'(bus_u.ap_ready),    32'd1);
      chk({tag, "_ce_count"}, 32'(ce_cnt),            32'(leff));
      chk({tag, "_idle_low"}, 32'(idle_low),          32'(leff + 2));
      if (leff > 0) chk({tag, "_max_addr"}, 32'(max_addr), 32'(leff - 1));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(bus_u.ap_done), 32'd0);
      chk({tag, "_idle_back"},  32'(bus_u.ap_idle), 32'd1);
    end

    // ap_start held high: back-to-back len=3 runs.
    fill_mem(0);
    @(negedge clk);
    set_start(1'b1, 3);
    @(posedge clk);
    cyc = 0; first = 0; second = 0;
    while (second == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus_u.ap_done) begin
        if (first == 0) begin
          first = cyc;
        end else begin
          second = cyc;
          set_start(1'b0, 3);
        end
      end
    end
    set_start(1'b0, 3);
    chk("b2b_first_done", 32'(first),          32'd5);
    chk("b2b_spacing",    32'(second - first), 32'd6);
    chk("b2b_ret",        bus_u.ap_return,     32'd8);
    repeat (2) @(negedge clk);
    chk("b2b_stopped",    32'(bus_u.ap_idle),  32'd1);

    // Reset asserted in the middle of a len=16 run, at k=7.
    @(negedge clk);
    set_start(1'b1, 16);
    @(posedge clk);
    cyc = 0; found = 1'b0;
    while (!found && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) set_start(1'b0, 16);
      if (bus_u.a_ce0 && bus_u.a_address0 == 4'd7) found = 1'b1;
    end
    chk("mid_found_k7",  32'(found),       32'd1);
    chk("mid_ret_held",  bus_u.ap_return,  32'd8);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_idle",  32'(bus_u.ap_idle), 32'd1);
    chk("mid_rst_ce",    32'(bus_u.a_ce0),   32'd0);
    chk("mid_rst_ret_u", bus_u.ap_return,    32'd0);
    chk("mid_rst_ret_s", bus_s.ap_return,    32'd0);
    chk("mid_rst_addr",  32'(bus_u.a_address0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one(16, 1'b0, cyc, ce_cnt, max_addr, idle_low);
    chk("post_rst_ret_u",   bus_u.ap_return, 32'h0000_0550);
    chk("post_rst_ret_s",   bus_s.ap_return, 32'h0000_0550);
    chk("post_rst_latency", 32'(cyc),        32'd18);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
